alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: NUM_REGS, 16, register-file depth; only 16 is supported, 4-bit register indices.
REQ-002 Clock/reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 instr  input  16  instruction word: [15:12] major op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; immediate forms use [7:0] as imm8.
REQ-006 instr_valid  input  1  instr is presented.
REQ-007 instr_ready  output  1  block can accept instr this cycle.
REQ-008 alu_op  output  8  opcode to ALU, equal to {instr[15:12], instr[7:4]}.
REQ-009 alu_a  output  16  ALU operand A, always R[Rdest].
REQ-010 alu_b  output  16  ALU operand B, either R[Rsrc] or the extended immediate.
REQ-011 alu_c  input  16  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-012 alu_flags  input  5  ALU flags {N,Z,F,L,C} in bits [4:0] = {4,3,2,1,0}.
REQ-013 psr  output  5  program status register.
REQ-014 done  output  1  one-cycle pulse when an instruction retires.
REQ-015 illegal  output  1  one-cycle pulse, coincident with done, for an unrecognised alu_op.
REQ-016 dbg_addr  input  4  debug register index.
REQ-017 dbg_data  output  16  combinational R[dbg_addr].

Function
REQ-018 FSM states: IDLE, DECODE, EXEC, WB; the FSM SHALL move IDLE->DECODE on instr_valid&instr_ready, then DECODE->EXEC->WB->IDLE unconditionally.
REQ-019 instr_ready SHALL be 1 only in IDLE; instr_valid outside IDLE is ignored and not queued.
REQ-020 On accept, instr SHALL be latched; later changes on instr do not affect the instruction in flight.
REQ-021 DECODE SHALL register alu_op, alu_a and alu_b, which then stay stable through EXEC and WB.
REQ-022 Immediate classes select alu_b as follows:
  - major op 0101, 1001, 1011, 0111: sign-extend imm8;
  - major op 0110: zero-extend imm8;
  - alu_op 1000000x or 10001xxx: sign-extend {instr[4], instr[3:0]} (5 bits);
  - all others: R[Rsrc].
REQ-023 EXEC SHALL capture alu_c and alu_flags into internal result/flag registers.
REQ-024 WB SHALL write the captured result to R[Rdest] unless alu_op is CMP(00001011), CMPI(1011xxxx), CMPUI(00001100), NOP(00000000) or illegal.
REQ-025 WB SHALL load psr from the captured flags only for ADD, ADDI, ADDC, ADDCI, SUB, SUBI, CMP, CMPI and CMPUI; all other instructions leave psr unchanged.
REQ-026 done SHALL pulse in WB; latency from the accept edge to done is 3 cycles; maximum throughput is one instruction per 4 cycles.
REQ-027 An instruction is illegal when alu_op is not in the ALU opcode set; an illegal instruction SHALL cause no register write, no psr change, and an illegal pulse with done.
REQ-028 When Rdest==Rsrc, both operands SHALL read the same pre-write value.
REQ-029 Register writes SHALL be visible on dbg_data the cycle after WB; dbg_addr==Rdest during WB shows the old value.
REQ-030 All 16 registers, including R0, SHALL be writable.

Reset
REQ-031 While reset is asserted, the block SHALL set:
  - state to IDLE;
  - all registers, psr, alu_op, alu_a and alu_b to 0;
  - done and illegal to 0.
REQ-032 The cycle after reset deasserts, instr_ready SHALL be 1.
REQ-033 Reset in DECODE, EXEC or WB SHALL abort the instruction: no register write and no psr update occur.

Structure
REQ-034 A shared package SHALL hold the 8-bit opcode constants (matching the ALU encodings), the FSM state enum and the psr bit indices.
REQ-035 The register file SHALL be the sub-module regfile16x16, with two combinational read ports, one debug read port, one synchronous write port and synchronous reset.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - After reset, ADDI R1,#5 (0x5105), then ADDI R1,#-5 (0x51FB) -> R1=0x0000 and psr[3]=1; done pulses 3 cycles after each accept.
  - With R2=0x7FFF and R3=0x0001, ADD R2,R3 (0x0253) -> R2=0x8000, psr[2]=1, psr[3]=0.
  - With R4=0x0003, CMPI R4,#3 (0xB403) -> R4 unchanged, psr[3]=1, psr[1]=0; a following AND R4,R4 (0x0414) leaves psr unchanged.
  - LSHI R5,#4 (0x8504) with R5=0x0001 -> R5=0x0010 and psr unchanged.
  - Hold instr_valid for 8 cycles -> exactly 2 accepts, instr_ready low in DECODE/EXEC/WB; instr 0x0FF0 (alu_op 0x0F) during the hold is processed normally.
  - Assert reset during EXEC of ADDI R6,#1 -> R6=0 and psr=0 after reset; instr 0x0EF0 (alu_op 0x0F is legal, so use 0xF000) -> illegal and done pulse, no writes.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcode encodings, FSM states,
// psr bit positions and opcode classification helpers.
package alu_ctrl_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'h01;
    localparam logic [7:0] OP_OR    = 8'h02;
    localparam logic [7:0] OP_XOR   = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_ADDU  = 8'h06;
    localparam logic [7:0] OP_ADDC  = 8'h07;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_CMPUI = 8'h0C;
    localparam logic [7:0] OP_MOV   = 8'h0D;
    localparam logic [7:0] OP_NOT   = 8'h0F;
    localparam logic [7:0] OP_LSHI  = 8'h80;
    localparam logic [7:0] OP_LSH   = 8'h84;
    localparam logic [7:0] OP_ASHU  = 8'h86;
    localparam logic [7:0] OP_ASHUI = 8'h88;

    localparam logic [3:0] MJ_SHIFT = 4'h8;
    localparam logic [3:0] MJ_ADDI  = 4'h5;
    localparam logic [3:0] MJ_ADDUI = 4'h6;
    localparam logic [3:0] MJ_ADDCI = 4'h7;
    localparam logic [3:0] MJ_SUBI  = 4'h9;
    localparam logic [3:0] MJ_CMPI  = 4'hB;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {B_REG, B_SEXT8, B_ZEXT8, B_SEXT5} bsel_t;

    function automatic logic op_legal(input logic [7:0] op);
        logic ok;
        casez (op)
            OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB,
            OP_CMP, OP_CMPUI, OP_MOV, OP_NOT, OP_LSH, OP_ASHU:      ok = 1'b1;
            8'b1000_000?, 8'b1000_1???:                            ok = 1'b1;
            8'b0101_????, 8'b0110_????, 8'b0111_????,
            8'b1001_????, 8'b1011_????:                            ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic bsel_t op_bsel(input logic [7:0] op);
        bsel_t sel;
        case (op[7:4])
            MJ_ADDI, MJ_ADDCI, MJ_SUBI, MJ_CMPI: sel = B_SEXT8;
            MJ_ADDUI:                            sel = B_ZEXT8;
            MJ_SHIFT: begin
                if (op[3:1] == 3'b000 || op[3] == 1'b1) begin
                    sel = B_SEXT5;
                end else begin
                    sel = B_REG;
                end
            end
            default:                             sel = B_REG;
        endcase
        return sel;
    endfunction

    // Compares and NOP only update flags (or nothing); illegal ops never write.
    function automatic logic op_writes(input logic [7:0] op);
        logic wr;
        casez (op)
            OP_NOP, OP_CMP, OP_CMPUI, 8'b1011_????: wr = 1'b0;
            default:                                wr = op_legal(op);
        endcase
        return wr;
    endfunction

    function automatic logic op_sets_psr(input logic [7:0] op);
        logic sp;
        casez (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_CMP, OP_CMPUI,
            8'b0101_????, 8'b0111_????, 8'b1001_????, 8'b1011_????: sp = 1'b1;
            default:                                               sp = 1'b0;
        endcase
        return sp;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 16x16 register file: two combinational operand ports, a debug read port,
// one synchronous write port, synchronous active-high reset.
module regfile16x16 #(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ra_addr,
    output logic [15:0] ra_data,
    input  logic [3:0]  rb_addr,
    output logic [15:0] rb_data,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [15:0] wd
);

    logic [15:0] regs_r [NUM_REGS];

    assign ra_data  = regs_r[ra_addr];
    assign rb_data  = regs_r[rb_addr];
    assign dbg_data = regs_r[dbg_addr];

    // Register storage with synchronous clear and single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (we) begin
            regs_r[wa] <= wd;
        end
    end

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle controller feeding an external combinational ALU:
// accept -> decode operands -> capture result -> write back.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t      state_r, state_s;
    logic [15:0] instr_r;
    logic [7:0]  alu_op_r;
    logic [15:0] alu_a_r, alu_b_r, alu_b_s;
    logic [15:0] res_r;
    logic [4:0]  flags_r, psr_r;
    logic        done_r, illegal_r, ready_r;
    logic [15:0] ra_data_s, rb_data_s;
    logic [7:0]  op_s;
    logic        we_s;

    assign op_s = {instr_r[15:12], instr_r[7:4]};
    assign we_s = (state_r == S_WB) && op_writes(alu_op_r);

    regfile16x16 #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (instr_r[11:8]),
        .ra_data  (ra_data_s),
        .rb_addr  (instr_r[3:0]),
        .rb_data  (rb_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we_s),
        .wa       (instr_r[11:8]),
        .wd       (res_r)
    );

    // Operand B source: register or one of the immediate extensions.
    always_comb begin
        alu_b_s = rb_data_s;
        case (op_bsel(op_s))
            B_SEXT8: alu_b_s = {{8{instr_r[7]}}, instr_r[7:0]};
            B_ZEXT8: alu_b_s = {8'h00, instr_r[7:0]};
            B_SEXT5: alu_b_s = {{11{instr_r[4]}}, instr_r[4:0]};
            default: alu_b_s = rb_data_s;
        endcase
    end

    // Next-state logic: only IDLE waits; the remaining states always advance.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (instr_valid) begin
                    state_s = S_DECODE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DECODE: state_s = S_EXEC;
            S_EXEC:   state_s = S_WB;
            S_WB:     state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Pipeline registers, psr and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            instr_r   <= 16'h0000;
            alu_op_r  <= 8'h00;
            alu_a_r   <= 16'h0000;
            alu_b_r   <= 16'h0000;
            res_r     <= 16'h0000;
            flags_r   <= 5'h00;
            psr_r     <= 5'h00;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            ready_r   <= (state_s == S_IDLE);
            done_r    <= (state_r == S_EXEC);
            illegal_r <= (state_r == S_EXEC) && !op_legal(alu_op_r);
            if (state_r == S_IDLE && instr_valid) begin
                instr_r <= instr;
            end
            if (state_r == S_DECODE) begin
                alu_op_r <= op_s;
                alu_a_r  <= ra_data_s;
                alu_b_r  <= alu_b_s;
            end
            if (state_r == S_EXEC) begin
                res_r   <= alu_c;
                flags_r <= alu_flags;
            end
            if (state_r == S_WB && op_sets_psr(alu_op_r)) begin
                psr_r <= flags_r;
            end
        end
    end

    assign instr_ready = ready_r;
    assign alu_op      = alu_op_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign psr         = psr_r;
    assign done        = done_r;
    assign illegal     = illegal_r;

endmodule
